// File: rtl/l1_cache_ctrl_fsm_if.sv
// Request/response bundle between the CPU port, the tag/data SRAM controls and the DRAM port
// of the L1 cache controller. The controller uses the slave modport.
interface l1_cache_ctrl_fsm_if;
    logic cache_cs;
    logic cache_we;
    logic cache_ack;
    logic cache_hit;
    logic cache_valid;
    logic cache_dirty_i;
    logic sram_we;
    logic cache_dirty_o;
    logic cpu_sel;
    logic dram_sel;
    logic dram_cs;
    logic dram_we;
    logic dram_ack;

    modport master (
        output cache_cs, cache_we, cache_hit, cache_valid, cache_dirty_i, dram_ack,
        input  cache_ack, sram_we, cache_dirty_o, cpu_sel, dram_sel, dram_cs, dram_we
    );

    modport slave (
        input  cache_cs, cache_we, cache_hit, cache_valid, cache_dirty_i, dram_ack,
        output cache_ack, sram_we, cache_dirty_o, cpu_sel, dram_sel, dram_cs, dram_we
    );
endinterface

// File: rtl/l1_cache_ctrl_fsm.sv
// Sequencing FSM for a direct-mapped write-back L1 data cache: hit/miss decision, dirty
// victim write-back, line refill from DRAM, CPU acknowledge and saturating perf counters.
module l1_cache_ctrl_fsm #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    l1_cache_ctrl_fsm_if.slave   bus,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt,
    output logic [CNT_WIDTH-1:0] wb_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    localparam int CNT_HIT  = 0;
    localparam int CNT_MISS = 1;
    localparam int CNT_WB   = 2;

    state_t state_q, state_d;
    logic   refill_q, refill_d;
    logic [2:0] cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_q [3];
    logic [CNT_WIDTH-1:0] cnt_d [3];

    always_comb begin
        state_d           = state_q;
        refill_d          = refill_q;
        cnt_inc           = 3'b000;
        bus.cache_ack     = 1'b0;
        bus.sram_we       = 1'b0;
        bus.cache_dirty_o = 1'b0;
        bus.cpu_sel       = 1'b0;
        bus.dram_sel      = 1'b0;
        bus.dram_cs       = 1'b0;
        bus.dram_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cache_cs) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (!bus.cache_cs) begin
                    state_d  = IDLE;
                    refill_d = 1'b0;
                end else if (bus.cache_hit) begin
                    bus.cache_ack = 1'b1;
                    if (bus.cache_we) begin
                        bus.sram_we       = 1'b1;
                        bus.cache_dirty_o = 1'b1;
                    end
                    // The re-compare after a refill is not a genuine hit.
                    if (refill_q) begin
                        refill_d = 1'b0;
                    end else begin
                        cnt_inc[CNT_HIT] = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_inc[CNT_MISS] = 1'b1;
                    if (bus.cache_valid && bus.cache_dirty_i) begin
                        cnt_inc[CNT_WB] = 1'b1;
                        state_d         = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.dram_cs  = 1'b1;
                bus.dram_we  = 1'b1;
                bus.dram_sel = 1'b1;
                if (bus.dram_ack) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.dram_cs = 1'b1;
                if (bus.dram_ack) begin
                    bus.sram_we = 1'b1;
                    bus.cpu_sel = 1'b1;
                    refill_d    = 1'b1;
                    state_d     = COMPARE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            refill_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            refill_q <= refill_d;
        end
    end

    // Counters saturate at all-ones rather than wrapping.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        always_comb begin
            cnt_d[gi] = cnt_q[gi];
            if (cnt_inc[gi] && (cnt_q[gi] != {CNT_WIDTH{1'b1}})) begin
                cnt_d[gi] = cnt_q[gi] + CNT_WIDTH'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q[gi] <= '0;
            end else begin
                cnt_q[gi] <= cnt_d[gi];
            end
        end
    end

    assign hit_cnt  = cnt_q[CNT_HIT];
    assign miss_cnt = cnt_q[CNT_MISS];
    assign wb_cnt   = cnt_q[CNT_WB];

endmodule

// File: tb/tb_l1_cache_ctrl_fsm.sv
// Directed bench for l1_cache_ctrl_fsm: expected CPU acks are queued when a request is issued
// and checked when the ack appears; a 2-bit-counter copy checks counter saturation.
module tb_l1_cache_ctrl_fsm;

    typedef struct {
        string tag;
        logic  sram_we;
        logic  cpu_sel;
        logic  dirty_o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
    logic [1:0]  s_hit_cnt, s_miss_cnt, s_wb_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_hit  = 0;
    int exp_miss = 0;
    int exp_wb   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    l1_cache_ctrl_fsm_if bus ();
    l1_cache_ctrl_fsm_if bus_s ();

    assign bus_s.cache_cs      = bus.cache_cs;
    assign bus_s.cache_we      = bus.cache_we;
    assign bus_s.cache_hit     = bus.cache_hit;
    assign bus_s.cache_valid   = bus.cache_valid;
    assign bus_s.cache_dirty_i = bus.cache_dirty_i;
    assign bus_s.dram_ack      = bus.dram_ack;

    l1_cache_ctrl_fsm #(.CNT_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
        .wb_cnt   (wb_cnt)
    );

    l1_cache_ctrl_fsm #(.CNT_WIDTH(2)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_s),
        .hit_cnt  (s_hit_cnt),
        .miss_cnt (s_miss_cnt),
        .wb_cnt   (s_wb_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    function automatic logic [6:0] outs();
        return {bus.cache_ack, bus.sram_we, bus.cache_dirty_o, bus.cpu_sel,
                bus.dram_sel, bus.dram_cs, bus.dram_we};
    endfunction

    task automatic drive(input logic cs, we, hit, valid, dirty, dack);
        bus.cache_cs      = cs;
        bus.cache_we      = we;
        bus.cache_hit     = hit;
        bus.cache_valid   = valid;
        bus.cache_dirty_i = dirty;
        bus.dram_ack      = dack;
    endtask

    // One clock: settle, score any ack against the queue, then advance past the edge.
    task automatic cyc(output logic acked);
        exp_t e;
        #1;
        acked = bus.cache_ack;
        if (acked) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_ack_sram_we"}, 32'(bus.sram_we), 32'(e.sram_we));
                chk({e.tag, "_ack_cpu_sel"}, 32'(bus.cpu_sel), 32'(e.cpu_sel));
                chk({e.tag, "_ack_dirty_o"}, 32'(bus.cache_dirty_o), 32'(e.dirty_o));
                chk({e.tag, "_ack_dram_cs"}, 32'(bus.dram_cs), 32'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_hit_cnt"},    hit_cnt,          32'(exp_hit));
        chk({tag, "_miss_cnt"},   miss_cnt,         32'(exp_miss));
        chk({tag, "_wb_cnt"},     wb_cnt,           32'(exp_wb));
        chk({tag, "_sat_hit"},    32'(s_hit_cnt),   32'(sat3(exp_hit)));
        chk({tag, "_sat_miss"},   32'(s_miss_cnt),  32'(sat3(exp_miss)));
        chk({tag, "_sat_wb"},     32'(s_wb_cnt),    32'(sat3(exp_wb)));
    endtask

    // Full CPU request; on a miss the DRAM acks in the last of wb_cyc/al_cyc cycles
    // and the refilled line hits on the re-compare.
    task automatic run_req(input string tag, input logic we, hit, valid, dirty,
                           input int wb_cyc, input int al_cyc);
        logic a;
        logic wb;
        wb = !hit && valid && dirty;
        sb.push_back('{tag, we, 1'b0, we});
        drive(1'b1, we, hit, valid, dirty, 1'b0);
        cyc(a);
        chk({tag, "_idle_ack"}, 32'(a), 32'd0);
        if (!hit) begin
            cyc(a);
            chk({tag, "_cmp_ack"}, 32'(a), 32'd0);
            exp_miss++;
            if (wb) begin
                exp_wb++;
                for (int i = 0; i < wb_cyc; i++) begin
                    bus.dram_ack = (i == wb_cyc - 1);
                    #1;
                    chk({tag, "_wb_ctl"}, 32'({bus.dram_cs, bus.dram_we, bus.dram_sel, bus.sram_we}),
                        32'b1110);
                    cyc(a);
                end
            end
            for (int i = 0; i < al_cyc; i++) begin
                bus.dram_ack = (i == al_cyc - 1);
                #1;
                if (i == al_cyc - 1) begin
                    chk({tag, "_refill_ctl"}, 32'({bus.dram_cs, bus.dram_we, bus.dram_sel,
                        bus.sram_we, bus.cpu_sel, bus.cache_dirty_o}), 32'b100110);
                end else begin
                    chk({tag, "_alloc_ctl"}, 32'({bus.dram_cs, bus.dram_we, bus.dram_sel,
                        bus.sram_we}), 32'b1000);
                end
                cyc(a);
            end
            bus.dram_ack  = 1'b0;
            bus.cache_hit = 1'b1;
        end else begin
            exp_hit++;
        end
        cyc(a);
        chk({tag, "_done_ack"}, 32'(a), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_counts(tag);
    endtask

    initial begin
        logic a;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_outs", 32'(outs()), 32'd0);
        check_counts("reset");

        run_req("rd_hit", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        run_req("wr_hit", 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);

        // Stray DRAM ack while idle must not move the FSM.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("idle_dack_outs", 32'(outs()), 32'd0);
        cyc(a);
        bus.dram_ack = 1'b0;
        #1;
        chk("idle_dack_after", 32'(outs()), 32'd0);
        cyc(a);

        run_req("clean_rd_miss", 1'b0, 1'b0, 1'b0, 1'b0, 0, 5);
        run_req("dirty_wr_miss", 1'b1, 1'b0, 1'b1, 1'b1, 3, 4);
        run_req("clean_wr_miss", 1'b1, 1'b0, 1'b1, 1'b0, 0, 2);

        // Request withdrawn during ALLOCATE: refill completes, no ack.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(a);
        cyc(a);
        exp_miss++;
        bus.cache_cs = 1'b0;
        #1;
        chk("drop_alloc1_dram_cs", 32'(bus.dram_cs), 32'd1);
        cyc(a);
        #1;
        chk("drop_alloc2_dram_cs", 32'(bus.dram_cs), 32'd1);
        cyc(a);
        bus.dram_ack = 1'b1;
        #1;
        chk("drop_refill_ctl", 32'({bus.dram_cs, bus.sram_we, bus.cpu_sel}), 32'b111);
        cyc(a);
        bus.dram_ack  = 1'b0;
        bus.cache_hit = 1'b1;
        cyc(a);
        chk("drop_cmp_no_ack", 32'(a), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("drop_idle_outs", 32'(outs()), 32'd0);
        check_counts("drop");

        run_req("hit_after_drop", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            run_req("hit_loop", 1'(k % 2), 1'b1, 1'b1, 1'b0, 0, 0);
        end

        // Reset in the middle of a write-back abandons the DRAM access.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(a);
        cyc(a);
        #1;
        chk("rst_wb_ctl", 32'({bus.dram_cs, bus.dram_we, bus.dram_sel}), 32'b111);
        cyc(a);
        rst = 1'b1;
        cyc(a);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_hit  = 0;
        exp_miss = 0;
        exp_wb   = 0;
        #1;
        chk("rst_mid_wb_outs", 32'(outs()), 32'd0);
        check_counts("rst_mid_wb");
        cyc(a);
        chk("rst_mid_wb_no_ack", 32'(a), 32'd0);

        run_req("post_rst_hit", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_cache_ctrl_fsm.md
Name: l1_cache_ctrl_fsm

Overview:
- Sequencing FSM for the direct-mapped, write-back L1 data cache.
- Sits between the CPU request port, the tag/data SRAM arrays, the CPU/DRAM data muxes and the external DRAM port.
- Decides hit or miss, writes back dirty victims, refills lines from DRAM and acknowledges the CPU.
- Keeps saturating hit, miss and write-back counters for performance measurement.

Parameters:
CNT_WIDTH, 32, width of each performance counter (saturating).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
cache_cs  input  1  CPU request valid; held high until cache_ack.
cache_we  input  1  CPU request is a write (1) or read (0); stable while cache_cs is high.
cache_ack  output  1  one-cycle pulse: the request is complete.
cache_hit  input  1  tag match and valid for the current index.
cache_valid  input  1  valid bit of the indexed line.
cache_dirty_i  input  1  dirty bit of the indexed line.
sram_we  output  1  write enable for the tag and data SRAMs.
cache_dirty_o  output  1  dirty bit written with the tag.
cpu_sel  output  1  SRAM write-data source: 0 = CPU word merge, 1 = DRAM line.
dram_sel  output  1  DRAM address source: 1 = victim tag/index, 0 = CPU address.
dram_cs  output  1  DRAM request valid.
dram_we  output  1  DRAM request is a write-back.
dram_ack  input  1  DRAM transaction complete (single-cycle pulse).
hit_cnt  output  CNT_WIDTH  number of first-pass hits.
miss_cnt  output  CNT_WIDTH  number of misses.
wb_cnt  output  CNT_WIDTH  number of dirty write-backs.

Behaviour:
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE. The state register and counters update synchronously.
- All request outputs are decoded combinationally from state and inputs.
- Every output not listed as asserted in a state is 0.
- Reset:
  - State goes to IDLE; all counters clear to 0; internal refill flag clears to 0.
  - Outputs are all 0 in the cycle after rst is sampled high.
  - A reset mid-transaction abandons the DRAM access: dram_cs drops the next cycle and no ack is issued.
- IDLE:
  - cache_cs=1 -> COMPARE next cycle. SRAM read data is valid in COMPARE.
  - cache_cs=0 -> stay in IDLE.
- COMPARE:
  - cache_cs=0 (request withdrawn): go to IDLE. No ack, no counter change, refill flag clears.
  - Hit, read: cache_ack=1, then IDLE.
  - Hit, write: sram_we=1, cpu_sel=0, cache_dirty_o=1, cache_ack=1, then IDLE.
  - Hit with refill flag=0: hit_cnt+1.
  - Hit with refill flag=1: hit_cnt does not change; refill flag clears.
  - Miss with cache_valid&cache_dirty_i: go to WRITEBACK; miss_cnt+1, wb_cnt+1.
  - Miss otherwise: go to ALLOCATE; miss_cnt+1.
- WRITEBACK:
  - dram_cs=1, dram_we=1, dram_sel=1, held until dram_ack.
  - dram_ack=1 -> ALLOCATE next cycle.
  - cache_cs changes are ignored here; the transaction always completes.
- ALLOCATE:
  - dram_cs=1, dram_we=0, dram_sel=0, held until dram_ack.
  - In the dram_ack cycle: sram_we=1, cpu_sel=1, cache_dirty_o=0, refill flag sets to 1, then COMPARE.
  - The re-compare hits. A write then merges the CPU word and sets dirty.
- Latency from cache_cs rising to cache_ack:
  - Hit: 2 cycles (ack in cycle 2).
  - Clean miss: 2 + ALLOCATE cycles + 1.
  - Dirty miss: additionally adds the WRITEBACK cycles.
- dram_ack outside WRITEBACK/ALLOCATE is ignored.
- cache_ack never asserts in the same cycle as dram_cs.
- Counters saturate at 2^CNT_WIDTH-1; no wrap.
- Simultaneous increments of miss_cnt and wb_cnt are independent.

Test Plan:
- Read hit: preload a valid line; cache_cs=1, we=0, hit=1 -> ack in cycle 2, sram_we=0, dram_cs never 1, hit_cnt=1, miss_cnt=0.
- Write hit: same with we=1 -> in the ack cycle sram_we=1, cpu_sel=0, cache_dirty_o=1; hit_cnt=1.
- Clean read miss: hit=0, valid=0, dram_ack after 5 cycles -> ALLOCATE with dram_cs=1, dram_we=0.
  - In the ack cycle: sram_we=1, cpu_sel=1, dirty_o=0.
  - Re-compare with hit=1 -> cache_ack; miss_cnt=1, hit_cnt=0, wb_cnt=0.
- Dirty write miss: valid=1, dirty=1, hit=0 -> WRITEBACK with dram_we=1, dram_sel=1 until dram_ack, then ALLOCATE.
  - Refill, then re-compare: write with dirty_o=1 and ack.
  - wb_cnt=1, miss_cnt=1.
- cache_cs dropped during ALLOCATE -> DRAM read still completes with refill write, COMPARE, then IDLE; no ack issued.
- rst=1 mid-WRITEBACK -> dram_cs=0 the next cycle, state IDLE, all counters 0. CNT_WIDTH=2 with 5 hits -> hit_cnt holds at 3.
